// File: rtl/vid_pkg.sv
// Shared video-pipeline definitions: raster defaults, coordinate types and
// the bounding-box accumulator record with its merge helper.
package vid_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;

  typedef logic [9:0]  coord_t;
  typedef logic [18:0] count_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2,
    WAIT   = 2'd3
  } bbox_state_t;

  typedef struct packed {
    coord_t xmin;
    coord_t xmax;
    coord_t ymin;
    coord_t ymax;
    count_t count;
  } bbox_acc_t;

  // Empty box: min edges at the top of the range so the first hit replaces them.
  localparam bbox_acc_t ACC_INIT = '{xmin: '1, xmax: '0, ymin: '1, ymax: '0, count: '0};

  function automatic bbox_acc_t acc_merge(input bbox_acc_t a, input coord_t h,
                                          input coord_t v);
    bbox_acc_t r;
    r = a;
    if (h < r.xmin) r.xmin = h;
    if (h > r.xmax) r.xmax = h;
    if (v < r.ymin) r.ymin = v;
    if (v > r.ymax) r.ymax = v;
    if (r.count != '1) r.count = r.count + count_t'(1);
    return r;
  endfunction

endpackage

// File: rtl/pixel_counter.sv
// Raster position tracker: h/v counters advanced by the pixel enable, with
// synchronous Frame_start realignment and start-of-frame detection.
module pixel_counter
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   Value,
  input  logic   Frame_start,
  output coord_t h,
  output coord_t v,
  output logic   active,
  output logic   last_active,
  output logic   sof
);

  coord_t hcount;
  coord_t vcount;
  logic   armed;
  logic   line_end;
  logic   frame_end;

  // Position of the pixel presented this cycle; Frame_start forces it to the origin.
  assign h = Frame_start ? '0 : hcount;
  assign v = Frame_start ? '0 : vcount;

  assign line_end    = (h == coord_t'(H_TOTAL - 1));
  assign frame_end   = line_end && (v == coord_t'(V_TOTAL - 1));
  assign active      = (h < coord_t'(H_ACTIVE)) && (v < coord_t'(V_ACTIVE));
  assign last_active = (h == coord_t'(H_ACTIVE - 1)) && (v == coord_t'(V_ACTIVE - 1));

  // armed marks an origin reached by a wrap or an idle Frame_start, not by reset.
  assign sof = Value && (Frame_start || armed);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hcount <= '0;
      vcount <= '0;
      armed  <= 1'b0;
    end else if (Value) begin
      hcount <= line_end ? '0 : h + coord_t'(1);
      if (line_end) vcount <= frame_end ? '0 : v + coord_t'(1);
      else          vcount <= v;
      armed  <= frame_end;
    end else if (Frame_start) begin
      hcount <= '0;
      vcount <= '0;
      armed  <= 1'b1;
    end
  end

endmodule

// File: rtl/mask_bbox.sv
// Per-frame bounding box and set-pixel count of a 1-bit mask stream, published
// with a one-cycle Frame_done pulse after the last active pixel.
module mask_bbox
  import vid_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_TOTAL    = DEF_H_TOTAL,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_TOTAL    = DEF_V_TOTAL,
  parameter int MIN_PIXELS = 16
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   Value,
  input  logic   Data_in,
  input  logic   Frame_start,
  output coord_t Box_xmin,
  output coord_t Box_xmax,
  output coord_t Box_ymin,
  output coord_t Box_ymax,
  output count_t Pix_count,
  output logic   Box_valid,
  output logic   Frame_done
);

  coord_t      h;
  coord_t      v;
  logic        active;
  logic        last_active;
  logic        sof;
  bbox_state_t state;
  bbox_state_t state_nxt;
  bbox_acc_t   acc;
  bbox_acc_t   acc_nxt;
  logic        collect;
  logic        report;
  logic        valid_nxt;

  pixel_counter #(
    .H_ACTIVE(H_ACTIVE),
    .H_TOTAL (H_TOTAL),
    .V_ACTIVE(V_ACTIVE),
    .V_TOTAL (V_TOTAL)
  ) u_pixel_counter (
    .CLK        (CLK),
    .RST        (RST),
    .Value      (Value),
    .Frame_start(Frame_start),
    .h          (h),
    .v          (v),
    .active     (active),
    .last_active(last_active),
    .sof        (sof)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    collect   = sof || (Value && (state == ACCUM));
    acc_nxt   = sof ? ACC_INIT : acc;
    if (collect && active && Data_in) acc_nxt = acc_merge(acc_nxt, h, v);
    report    = collect && last_active;
    valid_nxt = (acc_nxt.count >= count_t'(MIN_PIXELS));

    // A start of frame anywhere (including mid-ACCUM) discards the running box.
    state_nxt = state;
    if (report)                state_nxt = REPORT;
    else if (sof)              state_nxt = ACCUM;
    else if (state == REPORT)  state_nxt = WAIT;
  end

  // NOTE: accumulators are plain flops, so they take the reset value like any other state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      acc   <= ACC_INIT;
    end else begin
      state <= state_nxt;
      if (collect) acc <= acc_nxt;
    end
  end

  // Results include the last pixel's own contribution, hence taken from acc_nxt.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Box_xmin   <= '0;
      Box_xmax   <= '0;
      Box_ymin   <= '0;
      Box_ymax   <= '0;
      Pix_count  <= '0;
      Box_valid  <= 1'b0;
      Frame_done <= 1'b0;
    end else begin
      Frame_done <= report;
      if (report) begin
        Box_xmin  <= valid_nxt ? acc_nxt.xmin : '0;
        Box_xmax  <= valid_nxt ? acc_nxt.xmax : '0;
        Box_ymin  <= valid_nxt ? acc_nxt.ymin : '0;
        Box_ymax  <= valid_nxt ? acc_nxt.ymax : '0;
        Pix_count <= acc_nxt.count;
        Box_valid <= valid_nxt;
      end
    end
  end

endmodule

// File: doc/mask_bbox.md
Name: mask_bbox

Overview:
- Consumes the binary 1-bit pixel stream produced by the 3x3 erosion stage.
- Tracks image position with its own h/v counters and accumulates, per frame, the bounding box and count of set mask pixels inside the active area.
- At the end of the active area it publishes the results with a one-cycle Frame_done pulse; the downstream object-tracking/overlay logic reads them.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, enabled pixels per line including blanking
- V_ACTIVE, 480, visible lines per frame
- V_TOTAL, 525, lines per frame including blanking
- MIN_PIXELS, 16, minimum set-pixel count for Box_valid

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous active-low reset
- Value  in  1  pixel enable; a pixel is consumed only on cycles with Value=1
- Data_in  in  1  eroded mask bit for the current pixel
- Frame_start  in  1  marks the current cycle's pixel as position (0,0); synchronous
- Box_xmin  out  10  left edge of box
- Box_xmax  out  10  right edge of box
- Box_ymin  out  10  top edge of box
- Box_ymax  out  10  bottom edge of box
- Pix_count  out  19  number of set pixels in last frame
- Box_valid  out  1  Pix_count >= MIN_PIXELS for last frame
- Frame_done  out  1  one-cycle pulse when outputs update

Behaviour:
- Reset (RST=0, async):
  - All outputs are 0.
  - Counters are (0,0).
  - Accumulators are cleared.
  - The FSM enters IDLE.
- Counters:
  - hcount runs 0..H_TOTAL-1 and vcount runs 0..V_TOTAL-1.
  - They advance only when Value=1.
  - hcount wraps to 0 and increments vcount; at (H_TOTAL-1,V_TOTAL-1) both wrap to (0,0).
- Frame_start:
  - With Value=1: the pixel this cycle is processed as (0,0); counters become (1,0).
  - With Value=0: counters are set to (0,0); no pixel is consumed.
  - Frame_start has priority over normal increment.
- Active pixel: hcount < H_ACTIVE and vcount < V_ACTIVE. Blanking pixels never update accumulators.
- Accumulators:
  - Initial values: xmin=ymin=10'h3FF, xmax=ymax=0, count=0.
  - On an active pixel with Data_in=1: xmin=min(xmin,h), xmax=max(xmax,h), ymin=min, ymax=max, count+1.
  - count saturates at 2^19-1.
- FSM states:
  - IDLE: ignore data until a Frame_start, or until counters wrap to (0,0), then go to ACCUM with cleared accumulators. The pixel on that cycle is included.
  - ACCUM: accumulate. When pixel (H_ACTIVE-1,V_ACTIVE-1) is consumed, including its own contribution, go to REPORT.
  - REPORT (1 cycle):
    - Register outputs and assert Frame_done=1.
    - Box_valid = (count >= MIN_PIXELS).
    - If not valid, the Box_* outputs are driven 0; Pix_count still reports the true count.
    - Then go to WAIT.
  - WAIT: hold outputs. On Frame_start or counter wrap to (0,0), clear accumulators and go to ACCUM, consuming that pixel.
- Latency: Frame_done and the new outputs appear on the clock edge after the last active pixel is accepted, then hold until the next REPORT.
- Frame_done is high for exactly 1 cycle and never in consecutive cycles.
- Frame_start in ACCUM before the end of the active area aborts the frame:
  - Accumulators are discarded.
  - No Frame_done is issued.
  - Accumulation restarts from (0,0) with the current pixel.
- Value=0 for arbitrary stretches: all state holds; REPORT still occurs only after the last active pixel is consumed.
- Arithmetic:
  - Comparisons are unsigned, 10-bit.
  - A count of 307200 fits in 19 bits; saturation logic is still required.

Decomposition:
- Shared package vid_pkg holds:
  - H_ACTIVE/H_TOTAL/V_ACTIVE/V_TOTAL defaults.
  - typedef coord_t = logic [9:0].
  - The FSM state enum bbox_state_t {IDLE, ACCUM, REPORT, WAIT}.
- One sub-module, pixel_counter: h/v counter with Value enable, Frame_start sync clear, wrap logic, and Active/Last_active flags. Reused by the overlay stage.

Test Plan:
- Single set pixel at (100,50), Value=1 every cycle, Frame_start at frame begin -> after pixel (639,479):
  - Frame_done pulses once.
  - Box=(100,100,50,50), Pix_count=1, Box_valid=0, Box_* driven 0.
- Filled rectangle x 200..209, y 300..309 with MIN_PIXELS=16 -> Box=(200,209,300,309), Pix_count=100, Box_valid=1.
- Set pixels at (0,0), (639,479), plus set bits in blanking (x=700, y=10 and x=5, y=500) -> Box=(0,639,0,479), Pix_count=2; blanking ignored.
- Empty frame -> Frame_done pulses, Pix_count=0, Box_valid=0, all Box_*=0.
- Value toggled 1/0 every cycle with the rectangle from the second scenario -> identical results; Frame_done delayed accordingly.
- Mid-frame events:
  - Frame_start at (320,240) of frame N -> no Frame_done for frame N; the next report covers only pixels from the restart.
  - RST low mid-ACCUM -> outputs 0 immediately; first report only after a new Frame_start.
